// File: rtl/dcache_snoop_bus.sv
// Snooping bus shared by two Dcaches and main memory: arbitrates requests, broadcasts
// the grant, collects a peer snoop response or fetches from memory, and returns the fill.
module dcache_snoop_bus #(
   parameter int TAG_W     = 20,
   parameter int IDX_W     = 6,
   parameter int WORD_W    = 64,
   parameter int SNOOP_WIN = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             Dcache2bus_req_en_i,
   input  logic [1:0][TAG_W-1:0]  Dcache2bus_req_tag_i,
   input  logic [1:0][IDX_W-1:0]  Dcache2bus_req_idx_i,
   input  logic [1:0][WORD_W-1:0] Dcache2bus_req_data_i,
   input  logic [1:0][1:0]        Dcache2bus_req_message_i,
   input  logic [1:0]             Dcache2bus_rsp_vld_i,
   input  logic [1:0][WORD_W-1:0] Dcache2bus_rsp_data_i,
   output logic                   bus2Dcache_req_ack_o,
   output logic                   bus2Dcache_req_id_o,
   output logic [TAG_W-1:0]       bus2Dcache_req_tag_o,
   output logic [IDX_W-1:0]       bus2Dcache_req_idx_o,
   output logic [1:0]             bus2Dcache_req_message_o,
   output logic                   bus2Dcache_rsp_vld_o,
   output logic                   bus2Dcache_rsp_id_o,
   output logic [WORD_W-1:0]      bus2Dcache_rsp_data_o,
   output logic                   bus2mem_req_o,
   output logic                   bus2mem_we_o,
   output logic [63:0]            bus2mem_addr_o,
   output logic [WORD_W-1:0]      bus2mem_data_o,
   input  logic                   mem2bus_ack_i,
   input  logic                   mem2bus_rdata_vld_i,
   input  logic [WORD_W-1:0]      mem2bus_rdata_i
);

   localparam logic [1:0] MSG_NONE  = 2'd0;
   localparam logic [1:0] MSG_GET_S = 2'd1;
   localparam logic [1:0] MSG_PUT_M = 2'd3;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] GRANT  = 3'd1;
   localparam logic [2:0] SNOOP  = 3'd2;
   localparam logic [2:0] MEM_RD = 3'd3;
   localparam logic [2:0] MEM_WR = 3'd4;
   localparam logic [2:0] RSP    = 3'd5;

   localparam int CW = $clog2(SNOOP_WIN + 1);

   logic [2:0]        state;
   logic              id_q;
   logic [TAG_W-1:0]  tag_q;
   logic [IDX_W-1:0]  idx_q;
   logic [1:0]        msg_q;
   logic [WORD_W-1:0] data_q;
   logic [CW-1:0]     cnt;
   logic              wb_pending;
   logic              rd_acked;
   logic              prio;

   logic [1:0] vreq;
   logic       win;
   logic       peer_vld;
   logic       rd_req;
   logic       wr_req;
   logic [63:0] addr;

   assign vreq[0] = Dcache2bus_req_en_i[0] && (Dcache2bus_req_message_i[0] != MSG_NONE);
   assign vreq[1] = Dcache2bus_req_en_i[1] && (Dcache2bus_req_message_i[1] != MSG_NONE);
   // prio names the cpu that wins a tie; it flips away from whoever was just granted
   assign win      = (vreq == 2'b11) ? prio : vreq[1];
   assign peer_vld = Dcache2bus_rsp_vld_i[~id_q];
   assign addr     = 64'({tag_q, idx_q, 3'b000});

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         id_q       <= 1'b0;
         tag_q      <= '0;
         idx_q      <= '0;
         msg_q      <= MSG_NONE;
         data_q     <= '0;
         cnt        <= '0;
         wb_pending <= 1'b0;
         rd_acked   <= 1'b0;
         prio       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|vreq) begin
               id_q   <= win;
               tag_q  <= Dcache2bus_req_tag_i[win];
               idx_q  <= Dcache2bus_req_idx_i[win];
               msg_q  <= Dcache2bus_req_message_i[win];
               data_q <= Dcache2bus_req_data_i[win];
               prio   <= ~win;
               state  <= GRANT;
            end
            GRANT: begin
               wb_pending <= 1'b0;
               rd_acked   <= 1'b0;
               if (msg_q == MSG_PUT_M) begin
                  state <= MEM_WR;
               end else begin
                  cnt   <= CW'(SNOOP_WIN);
                  state <= SNOOP;
               end
            end
            SNOOP: begin
               if (peer_vld) begin
                  data_q     <= Dcache2bus_rsp_data_i[~id_q];
                  wb_pending <= (msg_q == MSG_GET_S);
                  state      <= RSP;
               end else if (cnt <= CW'(1)) begin
                  cnt   <= '0;
                  state <= MEM_RD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            MEM_RD: begin
               if (mem2bus_ack_i) rd_acked <= 1'b1;
               // read data may arrive together with the ack
               if ((rd_acked || mem2bus_ack_i) && mem2bus_rdata_vld_i) begin
                  data_q <= mem2bus_rdata_i;
                  state  <= RSP;
               end
            end
            MEM_WR: if (mem2bus_ack_i) state <= IDLE;
            RSP: begin
               wb_pending <= 1'b0;
               state      <= wb_pending ? MEM_WR : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rd_req = (state == MEM_RD) && !rd_acked;
   assign wr_req = (state == MEM_WR);

   assign bus2Dcache_req_ack_o     = (state == GRANT);
   assign bus2Dcache_req_id_o      = bus2Dcache_req_ack_o && id_q;
   assign bus2Dcache_req_tag_o     = bus2Dcache_req_ack_o ? tag_q : '0;
   assign bus2Dcache_req_idx_o     = bus2Dcache_req_ack_o ? idx_q : '0;
   assign bus2Dcache_req_message_o = bus2Dcache_req_ack_o ? msg_q : MSG_NONE;

   assign bus2Dcache_rsp_vld_o  = (state == RSP);
   assign bus2Dcache_rsp_id_o   = bus2Dcache_rsp_vld_o && id_q;
   assign bus2Dcache_rsp_data_o = bus2Dcache_rsp_vld_o ? data_q : '0;

   assign bus2mem_req_o  = rd_req || wr_req;
   assign bus2mem_we_o   = wr_req;
   assign bus2mem_addr_o = bus2mem_req_o ? addr : '0;
   assign bus2mem_data_o = wr_req ? data_q : '0;

endmodule

// File: tb/tb_dcache_snoop_bus.sv
// Scoreboard bench for dcache_snoop_bus: a driver pushes expected grants, fills and
// memory accesses; a monitor pops and compares them as the DUT presents them.
module tb_dcache_snoop_bus;
   localparam int TAG_W = 20, IDX_W = 6, WORD_W = 64, SW = 2;
   localparam logic [1:0] NONE = 2'd0, GET_S = 2'd1, GET_M = 2'd2, PUT_M = 2'd3;

   logic clk = 0, rst = 1;
   logic [1:0]             req_en = '0;
   logic [1:0][TAG_W-1:0]  req_tag = '0;
   logic [1:0][IDX_W-1:0]  req_idx = '0;
   logic [1:0][WORD_W-1:0] req_data = '0;
   logic [1:0][1:0]        req_msg = '0;
   logic [1:0]             rsp_vld_in = '0;
   logic [1:0][WORD_W-1:0] rsp_data_in = '0;
   logic ack, ack_id, rsp_vld, rsp_id, mreq, mwe;
   logic [TAG_W-1:0] ack_tag;
   logic [IDX_W-1:0] ack_idx;
   logic [1:0] ack_msg;
   logic [WORD_W-1:0] rsp_data, mdata;
   logic [63:0] maddr;
   logic mem_ack = 0, rdata_vld = 0;
   logic [WORD_W-1:0] rdata = '0;

   dcache_snoop_bus #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WORD_W(WORD_W), .SNOOP_WIN(SW)) dut (
      .clk(clk), .rst(rst),
      .Dcache2bus_req_en_i(req_en), .Dcache2bus_req_tag_i(req_tag),
      .Dcache2bus_req_idx_i(req_idx), .Dcache2bus_req_data_i(req_data),
      .Dcache2bus_req_message_i(req_msg), .Dcache2bus_rsp_vld_i(rsp_vld_in),
      .Dcache2bus_rsp_data_i(rsp_data_in),
      .bus2Dcache_req_ack_o(ack), .bus2Dcache_req_id_o(ack_id),
      .bus2Dcache_req_tag_o(ack_tag), .bus2Dcache_req_idx_o(ack_idx),
      .bus2Dcache_req_message_o(ack_msg), .bus2Dcache_rsp_vld_o(rsp_vld),
      .bus2Dcache_rsp_id_o(rsp_id), .bus2Dcache_rsp_data_o(rsp_data),
      .bus2mem_req_o(mreq), .bus2mem_we_o(mwe), .bus2mem_addr_o(maddr),
      .bus2mem_data_o(mdata), .mem2bus_ack_i(mem_ack),
      .mem2bus_rdata_vld_i(rdata_vld), .mem2bus_rdata_i(rdata)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic id; logic [TAG_W-1:0] tag; logic [IDX_W-1:0] idx; logic [1:0] msg; } ack_t;
   typedef struct { logic id; logic [63:0] data; int lat; } rsp_t;
   typedef struct { logic we; logic [63:0] addr; logic [63:0] data; int rise; int hold; } mem_t;
   ack_t exp_ack[$];
   rsp_t exp_rsp[$];
   mem_t exp_mem[$];

   logic [63:0] ref_mem[logic [63:0]];
   logic [63:0] mem_store[logic [63:0]];
   int total = 0, bad = 0;
   int ack_dly = 0, rd_dly = 0;
   logic last_gnt = 1'b1;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mk_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
      return (64'(t) << (IDX_W + 3)) | (64'(i) << 3);
   endfunction
   function automatic logic [63:0] dflt(input logic [63:0] a);
      return {a[31:0] ^ 32'h5A5A_A5A5, ~a[31:0]};
   endfunction
   function automatic logic [63:0] ref_rd(input logic [63:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // memory: holds ack off for ack_dly cycles, returns read data rd_dly cycles after ack
   task automatic mem_proc();
      logic [63:0] a, d;
      logic w;
      mem_store[mk_addr(5, 3)] = 64'hDEAD;
      forever begin
         while (!mreq) @(negedge clk);
         repeat (ack_dly) @(negedge clk);
         a = maddr; w = mwe;
         if (w) mem_store[a] = mdata;
         else d = mem_store.exists(a) ? mem_store[a] : dflt(a);
         mem_ack = 1;
         if (!w && rd_dly == 0) begin rdata_vld = 1; rdata = d; end
         @(negedge clk);
         mem_ack = 0; rdata_vld = 0;
         if (!w && rd_dly > 0) begin
            repeat (rd_dly - 1) @(negedge clk);
            rdata_vld = 1; rdata = d;
            @(negedge clk);
            rdata_vld = 0;
         end
      end
   endtask

   task automatic mon();
      logic pa = 0, pr = 0;
      int ack_cyc = 0, rise = 0;
      ack_t ea; rsp_t er; mem_t em;
      forever begin
         @(negedge clk); #1;
         if (rst) begin pa = 0; pr = 0; end
         else begin
            if (ack) begin
               chk(!pa, "ack_back_to_back", 64'(pa), 64'd0);
               if (exp_ack.size() == 0) chk(0, "ack_unexpected", 64'(ack_id), 64'd0);
               else begin
                  ea = exp_ack.pop_front();
                  chk({ack_id, ack_tag, ack_idx, ack_msg} == {ea.id, ea.tag, ea.idx, ea.msg}, "ack_fields",
                      64'({ack_id, ack_tag, ack_idx, ack_msg}), 64'({ea.id, ea.tag, ea.idx, ea.msg}));
               end
               ack_cyc = cyc;
            end
            if (rsp_vld) begin
               if (exp_rsp.size() == 0) chk(0, "rsp_unexpected", rsp_data, 64'd0);
               else begin
                  er = exp_rsp.pop_front();
                  chk(rsp_id == er.id, "rsp_id", 64'(rsp_id), 64'(er.id));
                  chk(rsp_data == er.data, "rsp_data", rsp_data, er.data);
                  if (er.lat >= 0) chk(cyc - ack_cyc == er.lat, "rsp_latency", 64'(cyc - ack_cyc), 64'(er.lat));
               end
            end
            if (mreq && !pr) begin
               rise = cyc;
               if (exp_mem.size() > 0 && exp_mem[0].rise >= 0)
                  chk(cyc - ack_cyc == exp_mem[0].rise, "mem_req_start", 64'(cyc - ack_cyc), 64'(exp_mem[0].rise));
            end
            if (mreq && mem_ack) begin
               if (exp_mem.size() == 0) chk(0, "mem_unexpected", maddr, 64'd0);
               else begin
                  em = exp_mem.pop_front();
                  chk(mwe == em.we, "mem_we", 64'(mwe), 64'(em.we));
                  chk(maddr == em.addr, "mem_addr", maddr, em.addr);
                  if (em.we) chk(mdata == em.data, "mem_wdata", mdata, em.data);
                  chk(cyc - rise + 1 == em.hold, "mem_req_hold", 64'(cyc - rise + 1), 64'(em.hold));
               end
            end
            pa = ack; pr = mreq;
         end
      end
   endtask

   task automatic set_req(input logic c, input logic [1:0] m, input logic [TAG_W-1:0] t,
                          input logic [IDX_W-1:0] i, input logic [63:0] d);
      req_msg[c] = m; req_tag[c] = t; req_idx[c] = i; req_data[c] = d; req_en[c] = 1;
   endtask

   task automatic wait_drain();
      int g = 0;
      while ((exp_ack.size() + exp_rsp.size() + exp_mem.size()) != 0 && g < 300) begin
         @(negedge clk); g++;
      end
      if (g >= 300) chk(0, "drain_timeout", 64'(exp_mem.size() + exp_rsp.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   // peer_k: window cycle (1..SW) in which the peer responds, 0 for no response
   task automatic run_txn(input logic c, input logic [1:0] m, input logic [TAG_W-1:0] t,
                          input logic [IDX_W-1:0] i, input logic [63:0] d, input int peer_k,
                          input logic [63:0] pd, input int ad, input int rd, input bit noise);
      logic [63:0] a = mk_addr(t, i);
      int g = 0;
      ack_dly = ad; rd_dly = rd;
      exp_ack.push_back('{c, t, i, m});
      if (m == PUT_M) begin
         exp_mem.push_back('{1'b1, a, d, 1, ad + 1});
         ref_mem[a] = d;
      end else if (peer_k > 0) begin
         exp_rsp.push_back('{c, pd, 1 + peer_k});
         if (m == GET_S) begin
            exp_mem.push_back('{1'b1, a, pd, 2 + peer_k, ad + 1});
            ref_mem[a] = pd;
         end
      end else begin
         exp_mem.push_back('{1'b0, a, 64'd0, SW + 1, ad + 1});
         exp_rsp.push_back('{c, ref_rd(a), -1});
      end
      last_gnt = c;
      set_req(c, m, t, i, d);
      do begin @(negedge clk); g++; end while (!(ack && ack_id == c) && g < 50);
      req_en[c] = 0;
      if (g >= 50) chk(0, "ack_timeout", 64'd0, 64'd1);
      for (int k = 1; k <= SW; k++) begin
         @(negedge clk);
         rsp_vld_in = '0;
         if (k == peer_k) begin rsp_vld_in[~c] = 1; rsp_data_in[~c] = pd; end
         if (noise) begin rsp_vld_in[c] = 1'($urandom_range(0, 1)); rsp_data_in[c] = {$urandom, $urandom}; end
      end
      @(negedge clk);
      rsp_vld_in = '0;
      wait_drain();
   endtask

   // both cpus keep a PUT_M pending; grants must alternate starting with the non-last cpu
   task automatic rr_phase(input int n, input int ad);
      logic [63:0] dat[2][8];
      logic [TAG_W-1:0] tg[2][8];
      logic [IDX_W-1:0] ix[2][8];
      int cnt[2];
      int g = 0;
      logic w = ~last_gnt, c;
      ack_dly = ad;
      for (int j = 0; j < n; j++) for (int q = 0; q < 2; q++) begin
         dat[q][j] = {$urandom, $urandom}; tg[q][j] = TAG_W'($urandom_range(0, 7)); ix[q][j] = IDX_W'($urandom_range(0, 7));
      end
      for (int j = 0; j < 2 * n; j++) begin
         c = w ^ 1'(j);
         exp_ack.push_back('{c, tg[c][j/2], ix[c][j/2], PUT_M});
         exp_mem.push_back('{1'b1, mk_addr(tg[c][j/2], ix[c][j/2]), dat[c][j/2], 1, ad + 1});
         ref_mem[mk_addr(tg[c][j/2], ix[c][j/2])] = dat[c][j/2];
         last_gnt = c;
      end
      cnt[0] = 0; cnt[1] = 0;
      for (int q = 0; q < 2; q++) set_req(1'(q), PUT_M, tg[q][0], ix[q][0], dat[q][0]);
      while (!(cnt[0] == n && cnt[1] == n) && g < 500) begin
         @(negedge clk); g++;
         for (int q = 0; q < 2; q++) begin
            if (ack && ack_id == 1'(q) && req_en[q]) begin req_en[q] = 0; cnt[q]++; end
            else if (!req_en[q] && cnt[q] < n) set_req(1'(q), PUT_M, tg[q][cnt[q]], ix[q][cnt[q]], dat[q][cnt[q]]);
         end
      end
      if (g >= 500) chk(0, "rr_timeout", 64'(cnt[0] + cnt[1]), 64'(2 * n));
      req_en = '0;
      wait_drain();
   endtask

   task automatic check_idle_outputs(input string nm);
      chk({ack, ack_id, rsp_vld, rsp_id, mreq, mwe} == 6'd0, {nm, "_ctl"}, 64'({ack, ack_id, rsp_vld, rsp_id, mreq, mwe}), 64'd0);
      chk(ack_msg == NONE && ack_tag == '0 && ack_idx == '0, {nm, "_req_fields"}, 64'({ack_tag, ack_idx, ack_msg}), 64'd0);
      chk((rsp_data | mdata | maddr) == 64'd0, {nm, "_data"}, rsp_data | mdata | maddr, 64'd0);
   endtask

   initial begin
      int g;
      logic c;
      logic [1:0] m;
      int pk;
      fork
         mem_proc();
         mon();
         begin #2ms; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end
      join_none
      ref_mem[mk_addr(5, 3)] = 64'hDEAD;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 0;
      @(negedge clk);

      run_txn(0, GET_S, 5, 3, 0, 0, 0, 1, 2, 1);
      run_txn(1, GET_M, 9, 1, 0, 1, 64'h1234, 0, 0, 0);
      run_txn(0, GET_S, 7, 2, 0, 2, 64'h77, 1, 0, 0);
      rr_phase(3, 0);
      run_txn(1, PUT_M, 4, 4, 64'hAA, 0, 0, 2, 0, 0);
      run_txn(0, GET_S, 4, 4, 0, 0, 0, 0, 0, 1);

      for (int n = 0; n < 40; n++) begin
         c = 1'($urandom_range(0, 1));
         m = 2'($urandom_range(1, 3));
         pk = (m == PUT_M) ? 0 : $urandom_range(0, SW);
         run_txn(c, m, TAG_W'($urandom_range(0, 3)), IDX_W'($urandom_range(0, 3)), {$urandom, $urandom},
                 pk, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      rr_phase(2, 1);

      // reset while waiting on a memory read: the fill must never appear
      ack_dly = 6; rd_dly = 0;
      exp_ack.push_back('{1'b0, 20'h3, 6'h5, GET_M});
      set_req(0, GET_M, 20'h3, 6'h5, 0);
      g = 0;
      do begin @(negedge clk); g++; end while (!ack && g < 50);
      req_en = '0;
      g = 0;
      while (!mreq && g < 20) begin @(negedge clk); g++; end
      chk(mreq, "reset_test_reached_mem_rd", 64'(mreq), 64'd1);
      rst = 1;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      @(negedge clk);
      rst = 0;
      last_gnt = 1'b1;
      repeat (15) @(negedge clk);
      rr_phase(1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
